// File: rtl/dds_pkg.sv
// dds_pkg: shared defaults, pipeline latency, quadrant codes and sine table generator
package dds_pkg;
    localparam int DEF_PHASE_W = 32;
    localparam int DEF_LUT_AW  = 8;
    localparam int DEF_OUT_W   = 16;
    localparam int LATENCY     = 4;

    localparam logic [1:0] QUAD_I   = 2'd0;
    localparam logic [1:0] QUAD_II  = 2'd1;
    localparam logic [1:0] QUAD_III = 2'd2;
    localparam logic [1:0] QUAD_IV  = 2'd3;

    // Quarter-wave entry k of a table with 2^aw+1 points, rounded to ow-bit signed full scale
    function automatic int sin_word(int k, int aw, int ow);
        real amp;
        real ang;
        amp = real'((1 << (ow - 1)) - 1);
        ang = 3.14159265358979323846 * real'(k) / real'(1 << (aw + 1));
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction
endpackage

// File: rtl/dds_sin_rom.sv
// dds_sin_rom: quarter-wave sine table, synchronous read with registered output
module dds_sin_rom
    import dds_pkg::*;
#(
    parameter int AW = DEF_LUT_AW,
    parameter int DW = DEF_OUT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW:0]   addr,
    output logic [DW-1:0] data
);
    localparam int DEPTH = (1 << AW) + 1;

    logic [DW-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = DW'(sin_word(k, AW, DW));
    end

    // Registered table read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data <= '0;
        else        data <= rom[addr];
    end
endmodule

// File: rtl/dds_nco_fm.sv
// dds_nco_fm: FM-capable NCO with double-buffered frequency word and 4-stage sine pipeline
module dds_nco_fm
    import dds_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int LUT_AW  = DEF_LUT_AW,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [PHASE_W-1:0]        f0_in,
    input  logic                      f0_wr,
    input  logic                      f0_load,
    input  logic [PHASE_W-1:0]        fm_in,
    input  logic [PHASE_W-1:0]        phase_ofs,
    input  logic                      phase_clr,
    output logic                      fout,
    output logic signed [OUT_W-1:0]   dout,
    output logic                      dout_valid
);
    localparam logic [LUT_AW:0] QTR = {1'b1, {LUT_AW{1'b0}}};

    logic [PHASE_W-1:0] f0_sh;
    logic [PHASE_W-1:0] f0_act;
    logic [PHASE_W-1:0] acc;
    logic [LUT_AW+1:0]  p;
    logic [1:0]         q;
    logic [LUT_AW-1:0]  idx;
    logic [LUT_AW:0]    addr;
    logic               neg2;
    logic               neg3;
    logic [OUT_W-1:0]   rom_q;
    logic [LATENCY:0]   vld;

    assign q          = p[LUT_AW+1:LUT_AW];
    assign idx        = p[LUT_AW-1:0];
    assign fout       = acc[PHASE_W-1];
    assign dout_valid = vld[LATENCY];

    // Shadow and active frequency words; a same-edge write+load bypasses the shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f0_sh  <= '0;
            f0_act <= '0;
        end else begin
            if (f0_wr)   f0_sh  <= f0_in;
            if (f0_load) f0_act <= f0_wr ? f0_in : f0_sh;
        end
    end

    // Phase accumulator: clear wins over enable, wraps modulo 2^PHASE_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         acc <= '0;
        else if (phase_clr) acc <= '0;
        else if (en)        acc <= acc + f0_act + fm_in;
    end

    // Free-running pipeline: offset phase, mirrored address + sign, sign applied to table word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p    <= '0;
            addr <= '0;
            neg2 <= 1'b0;
            neg3 <= 1'b0;
            dout <= '0;
            vld  <= '0;
        end else begin
            p    <= (LUT_AW+2)'((acc + phase_ofs) >> (PHASE_W - LUT_AW - 2));
            addr <= (q == QUAD_II || q == QUAD_IV) ? QTR - {1'b0, idx} : {1'b0, idx};
            neg2 <= (q == QUAD_III || q == QUAD_IV);
            neg3 <= neg2;
            dout <= neg3 ? -rom_q : rom_q;
            vld  <= {vld[LATENCY-1:0], en};
        end
    end

    dds_sin_rom #(.AW(LUT_AW), .DW(OUT_W)) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .data  (rom_q)
    );
endmodule
